// File: rtl/bug_motion_ctl.sv
// rtl/bug_motion_ctl.sv - bug sprite motion, hit scoring and respawn sequencer
// Optional BUG_SPEEDUP_EN: speed grows with score[7:3], capped at 7.
module bug_motion_ctl #(
  parameter int SCREEN_W    = 1024,
  parameter int SCREEN_H    = 768,
  parameter int BUG_W       = 50,
  parameter int BUG_H       = 54,
  parameter int SPEED       = 2,
  parameter int HIDE_FRAMES = 30,
  parameter int LIVE_FRAMES = 180
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vblnk_in,
  input  logic        start,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] x_bugpos,
  output logic [11:0] y_bugpos,
  output logic        bug_visible,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [7:0]  score
);
  localparam logic [12:0] XMAX   = 13'(SCREEN_W - BUG_W);
  localparam logic [12:0] YMAX   = 13'(SCREEN_H - BUG_H);
  localparam logic [12:0] BW     = 13'(BUG_W);
  localparam logic [12:0] BH     = 13'(BUG_H);
  localparam logic [7:0]  LIVE_C = 8'(LIVE_FRAMES);
  localparam logic [7:0]  HIDE_C = 8'(HIDE_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT, S_RESPAWN} state_t;

  state_t      r_state, w_state;
  logic [11:0] r_x, r_y, w_x, w_y;
  logic        r_dx, r_dy, w_dx, w_dy;
  logic        r_vis, w_vis, r_hit, w_hit, r_miss, w_miss;
  logic [7:0]  r_score, w_score, r_cnt, w_cnt;
  logic [15:0] r_lfsr;
  logic        r_vblnk, r_mleft;

  logic        w_tick, w_click, w_inside, w_fb;
  logic [12:0] w_speed, w_rx, w_ry, w_spx, w_spy;
  logic [11:0] w_mx, w_my;
  logic        w_mdx, w_mdy;

  // Returns {new_dir_negative, new_pos}; all arithmetic in 13 bits so nothing wraps.
  function automatic logic [12:0] move_axis(input logic [11:0] pos, input logic neg,
                                            input logic [12:0] spd, input logic [12:0] lim);
    logic [12:0] p, s;
    p = {1'b0, pos};
    if (!neg) begin
      s = p + spd;
      move_axis = (s >= lim) ? {1'b1, lim[11:0]} : {1'b0, s[11:0]};
    end else begin
      s = p - spd;
      move_axis = (p < spd) ? 13'd0 : {1'b1, s[11:0]};
    end
  endfunction

`ifdef BUG_SPEEDUP_EN
  logic [5:0] w_sum;
  assign w_sum   = 6'(SPEED) + {1'b0, r_score[7:3]};
  assign w_speed = (w_sum > 6'd7) ? 13'd7 : {7'd0, w_sum};
`else
  assign w_speed = 13'(SPEED);
`endif

  assign w_tick   = vblnk_in & ~r_vblnk;
  assign w_click  = mouse_left & ~r_mleft;
  assign w_inside = ({1'b0, mouse_xpos} >= {1'b0, r_x}) && ({1'b0, mouse_xpos} < {1'b0, r_x} + BW) &&
                    ({1'b0, mouse_ypos} >= {1'b0, r_y}) && ({1'b0, mouse_ypos} < {1'b0, r_y} + BH);
  assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  assign {w_mdx, w_mx} = move_axis(r_x, r_dx, w_speed, XMAX);
  assign {w_mdy, w_my} = move_axis(r_y, r_dy, w_speed, YMAX);

  // Respawn folds the 10-bit random value back into the legal range.
  assign w_rx  = {3'd0, r_lfsr[9:0]};
  assign w_ry  = {3'd0, r_lfsr[15:6]};
  assign w_spx = (w_rx > XMAX) ? w_rx - XMAX : w_rx;
  assign w_spy = (w_ry > YMAX) ? w_ry - YMAX : w_ry;

  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_dx    = r_dx;
    w_dy    = r_dy;
    w_vis   = r_vis;
    w_hit   = 1'b0;
    w_miss  = 1'b0;
    w_score = r_score;
    w_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_vis = 1'b0;
        if (start) begin
          w_state = S_RUN;
          w_vis   = 1'b1;
          w_cnt   = 8'd0;
        end
      end
      S_RUN: begin
        w_vis = 1'b1;
        if (w_click && w_inside) begin
          w_hit   = 1'b1;
          w_score = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
          w_cnt   = 8'd0;
          w_vis   = 1'b0;
          w_state = S_HIT;
        end else if (w_tick) begin
          w_x   = w_mx;
          w_y   = w_my;
          w_dx  = w_mdx;
          w_dy  = w_mdy;
          w_cnt = r_cnt + 8'd1;
          if (w_cnt == LIVE_C) begin
            w_miss  = 1'b1;
            w_vis   = 1'b0;
            w_state = S_RESPAWN;
          end
        end
      end
      S_HIT: begin
        w_vis = 1'b0;
        if (w_tick) begin
          w_cnt = r_cnt + 8'd1;
          if (w_cnt == HIDE_C) w_state = S_RESPAWN;
        end
      end
      default: begin
        w_x     = w_spx[11:0];
        w_y     = w_spy[11:0];
        w_dx    = r_lfsr[0];
        w_dy    = r_lfsr[1];
        w_cnt   = 8'd0;
        w_vis   = 1'b1;
        w_state = S_RUN;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= 12'd487;
      r_y     <= 12'd357;
      r_dx    <= 1'b0;
      r_dy    <= 1'b0;
      r_vis   <= 1'b0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      r_score <= 8'd0;
      r_cnt   <= 8'd0;
      r_lfsr  <= 16'hACE1;
      r_vblnk <= 1'b0;
      r_mleft <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_dx    <= w_dx;
      r_dy    <= w_dy;
      r_vis   <= w_vis;
      r_hit   <= w_hit;
      r_miss  <= w_miss;
      r_score <= w_score;
      r_cnt   <= w_cnt;
      r_lfsr  <= {r_lfsr[14:0], w_fb};
      r_vblnk <= vblnk_in;
      r_mleft <= mouse_left;
    end
  end

  assign x_bugpos    = r_x;
  assign y_bugpos    = r_y;
  assign bug_visible = r_vis;
  assign hit_pulse   = r_hit;
  assign miss_pulse  = r_miss;
  assign score       = r_score;
endmodule

// File: tb/tb_bug_motion_ctl.sv
// tb/tb_bug_motion_ctl.sv - directed bench for bug_motion_ctl
module tb_bug_motion_ctl;
  localparam int XMAX = 974;
  localparam int YMAX = 714;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        vblnk_in = 1'b0;
  logic        start = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic        mouse_left = 1'b0;
  logic [11:0] x_bugpos, y_bugpos;
  logic        bug_visible, hit_pulse, miss_pulse;
  logic [7:0]  score;

  bug_motion_ctl dut (
    .pclk(pclk), .reset(reset), .vblnk_in(vblnk_in), .start(start),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_left(mouse_left),
    .x_bugpos(x_bugpos), .y_bugpos(y_bugpos), .bug_visible(bug_visible),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score)
  );

  always #5 pclk = ~pclk;

  // Reference LFSR, x^16+x^14+x^13+x^11+1, plus the value it held one cycle ago.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge pclk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_prev <= m_lfsr;
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int mx, my, sx, sy;
  bit mdx, mdy;
  int seen_miss, seen_hit, seen_x, seen_y;

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int speed_now();
`ifdef BUG_SPEEDUP_EN
    int s;
    s = 2 + (score >> 3);
    return (s > 7) ? 7 : s;
`else
    return 2;
`endif
  endfunction

  task automatic step_axis(inout int p, inout bit neg, input int lim, input int sp);
    if (!neg) begin
      if (p + sp >= lim) begin p = lim; neg = 1'b1; end
      else p = p + sp;
    end else begin
      if (p < sp) begin p = 0; neg = 1'b0; end
      else p = p - sp;
    end
  endtask

  task automatic load_respawn_model();
    int rx, ry;
    rx = int'(m_prev[9:0]);
    ry = int'(m_prev[15:6]);
    mx  = (rx > XMAX) ? rx - XMAX : rx;
    my  = (ry > YMAX) ? ry - YMAX : ry;
    mdx = m_prev[0];
    mdy = m_prev[1];
  endtask

  // One vblank rising edge; records what the tick edge produced.
  task automatic frame();
    vblnk_in = 1'b1;
    @(negedge pclk);
    seen_miss = miss_pulse;
    seen_hit  = hit_pulse;
    seen_x    = x_bugpos;
    seen_y    = y_bugpos;
    vblnk_in = 1'b0;
    @(negedge pclk);
  endtask

  initial begin
    int early_miss, hits;
    repeat (3) @(negedge pclk);
    check("reset_x", x_bugpos, 487);
    check("reset_y", y_bugpos, 357);
    check("reset_vis", bug_visible, 0);
    check("reset_score", score, 0);
    check("reset_pulses", {hit_pulse, miss_pulse}, 0);
    reset = 1'b0;
    @(negedge pclk);

    frame();
    check("idle_no_move", x_bugpos, 487);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    check("start_vis", bug_visible, 1);

    mouse_xpos = 12'd537; mouse_ypos = 12'd357; mouse_left = 1'b1;
    @(negedge pclk);
    check("outside_no_hit", hit_pulse, 0);
    mouse_left = 1'b0;
    @(negedge pclk);

    frame();
    check("tick1_x", x_bugpos, 489);
    check("tick1_y", y_bugpos, 359);
    check("tick1_vis", bug_visible, 1);
    check("tick1_score", score, 0);

    early_miss = 0;
    repeat (177) begin frame(); early_miss += seen_miss; end
    check("y_before_edge", y_bugpos, 713);
    check("x_after_178", x_bugpos, 843);
    frame();
    early_miss += seen_miss;
    check("y_clamp_edge", y_bugpos, 714);
    check("no_early_miss", early_miss, 0);
    frame();
    check("miss_on_180", seen_miss, 1);
    check("y_bounce_back", seen_y, 712);
    check("miss_one_cycle", miss_pulse, 0);
    check("miss_score", score, 0);
    load_respawn_model();
    check("miss_respawn_x", x_bugpos, mx);
    check("miss_respawn_y", y_bugpos, my);

    reset = 1'b1;
    @(negedge pclk);
    check("midreset_x", x_bugpos, 487);
    check("midreset_vis", bug_visible, 0);
    @(negedge pclk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;

    mouse_xpos = 12'd500; mouse_ypos = 12'd380; mouse_left = 1'b1;
    @(negedge pclk);
    check("hit_pulse", hit_pulse, 1);
    check("hit_score", score, 1);
    check("hit_hidden", bug_visible, 0);
    mouse_left = 1'b0;
    @(negedge pclk);
    check("hit_one_cycle", hit_pulse, 0);
    repeat (29) frame();
    check("hidden_29", bug_visible, 0);
    frame();
    check("respawn_vis", bug_visible, 1);
    load_respawn_model();
    check("respawn_x", x_bugpos, mx);
    check("respawn_y", y_bugpos, my);
    check("respawn_x_range", int'(x_bugpos <= 12'd974), 1);
    check("respawn_y_range", int'(y_bugpos <= 12'd714), 1);

    for (int i = 0; i < 5; i++) begin
      sx = speed_now();
      step_axis(mx, mdx, XMAX, sx);
      step_axis(my, mdy, YMAX, sx);
      frame();
      check("move_x", x_bugpos, mx);
      check("move_y", y_bugpos, my);
    end

    mouse_xpos = 12'(mx + 1); mouse_ypos = 12'(my + 1);
    mouse_left = 1'b1; vblnk_in = 1'b1;
    @(negedge pclk);
    check("tie_hit", hit_pulse, 1);
    check("tie_no_move_x", x_bugpos, mx);
    check("tie_no_move_y", y_bugpos, my);
    check("tie_score", score, 2);
    mouse_left = 1'b0; vblnk_in = 1'b0;
    @(negedge pclk);

    hits = 0;
    for (int i = 0; i < 254; i++) begin
      repeat (30) frame();
      mouse_xpos = x_bugpos; mouse_ypos = y_bugpos; mouse_left = 1'b1;
      @(negedge pclk);
      hits += hit_pulse;
      mouse_left = 1'b0;
      @(negedge pclk);
    end
    check("sat_hits", hits, 254);
    check("sat_score", score, 255);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
